sad_cal_16x16: RTL and testbench
================================

Name: sad_cal_16x16

Overview:
- Fully pipelined Sum-of-Absolute-Differences engine for one 16x16 pixel block per clock.
- Compares a current block (dina) against a reference block (refi) and returns the sum of the 256 per-pixel absolute differences.
- Fixed latency of 8 cycles, with a valid strobe.
- Sits in the motion-estimation datapath between the block fetch logic and the best-match comparator.

Parameters:
- DWIDTH, 8, pixel width in bits; sad width is DWIDTH+8.
- PIPE_STAGE, 8, pipeline depth in register stages. Only the value 8 is supported; instantiating with any other value is a usage error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- dina  input  256*DWIDTH  current block. Pixel (y,x) occupies bits [(y*16+x)*DWIDTH +: DWIDTH], with y and x in 0..15.
- refi  input  256*DWIDTH  reference block, same packing as dina.
- cal_en  input  1  when high, the dina/refi values are a valid computation request this cycle.
- sad  output  DWIDTH+8  sum of |dina(y,x) - refi(y,x)| over all 256 pixels, unsigned.
- sad_vld  output  1  high for exactly one cycle per accepted request.

Behaviour:
- Reset: every pipeline valid bit, every data register, sad and sad_vld clear to 0 immediately on rst=1.
- Accept rule: a request is accepted at every rising edge where cal_en=1. There is no backpressure; a new request may be accepted every cycle.
- Latency: a request accepted at edge t drives sad_vld=1 and its sad value from edge t+7 until edge t+8. That is 8 register stages; the first edge is the capture edge.
- Consecutive requests produce consecutive sad_vld pulses, in order.
- Requests with cal_en=0 produce no output; each gap in cal_en appears as a gap in sad_vld.
- Arithmetic:
  - |a-b| is computed on unsigned DWIDTH-bit operands and yields DWIDTH bits.
  - Each adder-tree level widens its result by 1 bit.
  - Final sum is DWIDTH+8 bits; no overflow is possible (maximum 255*256 = 0xFF00 for DWIDTH=8).
- Pipeline structure (required, so latency is exact):
  - Stage 1: 256 absolute differences plus pairwise add, registering 128 partial sums.
  - Stages 2..8: binary adder tree, 128→64→32→16→8→4→2→1.
  - The stage-8 register drives sad.
- Valid tracking: a 1-bit valid shift register of depth 8 runs alongside the data. Its last bit is sad_vld.
- Data gating: each stage's data register loads only when that stage's incoming valid bit is 1, otherwise it holds its value. Consequently, with sad_vld=0, sad holds the last valid result (0 after reset).
- Reset mid-operation: all in-flight requests are discarded. No sad_vld pulse for them appears after reset release. The first request accepted after release follows normal latency.

Optional Feature:
- Macro SAD_CAL_ZERO_IDLE_EN.
- Defined: sad is forced to 0 in every cycle where sad_vld=0 (output AND-masked by sad_vld).
- Not defined: sad holds the last valid value as described in Behaviour.
- sad_vld timing is identical in both builds.

Decomposition:
- Package sad_pkg:
  - localparams BLK_DIM=16, BLK_PIX=256, SAD_LATENCY=8.
  - function absdiff(a,b).
  - function pix_idx(y,x) returning the packed bit offset.
- Sub-module sad_add_level:
  - One registered tree level, parameterised by input count and input width.
  - Valid-gated load.
  - Instantiated 7 times with halving input counts.

Test Plan:
- Reset, then inputs all-zero with cal_en=1 for 1 cycle → sad_vld=1 exactly 8 edges after capture; sad=0x0000.
- Back-to-back 4 cycles (dina=0/refi=FF, FF/FF, FF/0, 0/0) → 4 consecutive sad_vld cycles; sad=0xFF00, 0x0000, 0xFF00, 0x0000, in order.
- Single pixel differs: dina(15,15)=0x80, refi all 0, rest equal → sad=0x0080, so the last pixel's packing is checked.
- Random dina/refi with random cal_en, ~6% and ~94% duty, 32k cycles → every sad_vld matches a reference model delaying cal_en by 8; sad equals the model sum.
- Assert rst for 1 cycle while 5 requests are in flight → sad_vld=0 and sad=0 immediately; no stale pulse afterwards; next request returns correctly after 8 edges.
- With SAD_CAL_ZERO_IDLE_EN defined, idle cycles after a 0xFF00 result → sad=0 whenever sad_vld=0. Without the macro, sad stays 0xFF00.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared constants and helpers for the 16x16 SAD engine.
// Pixel packing and absolute-difference arithmetic live here.
package sad_pkg;

    localparam int BLK_DIM     = 16;
    localparam int BLK_PIX     = 256;
    localparam int SAD_LATENCY = 8;

    // Unsigned |a-b|; callers zero-extend and truncate to pixel width.
    function automatic logic [31:0] absdiff(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Bit offset of pixel (y,x) inside a packed block of w-bit pixels.
    function automatic int pix_idx(
        input int y,
        input int x,
        input int w = 8
    );
        return (y * BLK_DIM + x) * w;
    endfunction

endpackage

// File: rtl/sad_add_level.sv
// One registered level of the SAD adder tree.
// Sums adjacent input pairs; loads only when the incoming valid is set.
module sad_add_level #(
    parameter int N_IN = 2,
    parameter int IW   = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_vld,
    input  logic [N_IN*IW-1:0]          i_data,
    output logic [(N_IN/2)*(IW+1)-1:0]  o_data
);

    localparam int OW = IW + 1;

    logic [(N_IN/2)*OW-1:0] r_sum;

    // Pairwise add, holding the previous result on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_vld) begin
            for (int i = 0; i < N_IN / 2; i++) begin
                r_sum[i*OW +: OW] <= {1'b0, i_data[(2*i)*IW +: IW]}
                                   + {1'b0, i_data[(2*i+1)*IW +: IW]};
            end
        end
    end

    assign o_data = r_sum;

endmodule

// File: rtl/sad_cal_16x16.sv
// 16x16 SAD engine: one block per clock, 8-cycle latency.
// Define SAD_CAL_ZERO_IDLE_EN to force sad to 0 whenever sad_vld is low.
module sad_cal_16x16
    import sad_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int PIPE_STAGE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BLK_PIX*DWIDTH-1:0]   dina,
    input  logic [BLK_PIX*DWIDTH-1:0]   refi,
    input  logic                        cal_en,
    output logic [DWIDTH+7:0]           sad,
    output logic                        sad_vld
);

    localparam int W1 = DWIDTH + 1;
    localparam int NL = SAD_LATENCY - 1;

    if (PIPE_STAGE != SAD_LATENCY) begin : g_bad_pipe_stage
        $error("sad_cal_16x16: PIPE_STAGE must be 8");
    end

    logic [DWIDTH-1:0]           w_ad [BLK_PIX];
    logic [(BLK_PIX/2)*W1-1:0]   r_s1;
    logic [SAD_LATENCY-1:0]      r_vld;
    logic [DWIDTH+7:0]           w_final;

    // Per-pixel absolute differences.
    always_comb begin
        w_ad = '{default: '0};
        for (int y = 0; y < BLK_DIM; y++) begin
            for (int x = 0; x < BLK_DIM; x++) begin
                w_ad[y*BLK_DIM+x] = DWIDTH'(absdiff(
                    32'(dina[pix_idx(y, x, DWIDTH) +: DWIDTH]),
                    32'(refi[pix_idx(y, x, DWIDTH) +: DWIDTH])));
            end
        end
    end

    // Stage 1: capture pairwise sums of the differences on a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (cal_en) begin
            for (int k = 0; k < BLK_PIX / 2; k++) begin
                r_s1[k*W1 +: W1] <= {1'b0, w_ad[2*k]}
                                  + {1'b0, w_ad[2*k+1]};
            end
        end
    end

    // Valid bits travelling alongside the data, one per stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[SAD_LATENCY-2:0], cal_en};
        end
    end

    for (genvar lv = 0; lv < NL; lv++) begin : g_lvl
        localparam int NI = (BLK_PIX / 2) >> lv;
        localparam int IW = W1 + lv;

        logic [NI*IW-1:0]          w_in;
        logic [(NI/2)*(IW+1)-1:0]  w_out;

        if (lv == 0) begin : g_first
            assign w_in = r_s1;
        end else begin : g_next
            assign w_in = g_lvl[lv-1].w_out;
        end

        sad_add_level #(
            .N_IN (NI),
            .IW   (IW)
        ) u_lvl (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (r_vld[lv]),
            .i_data (w_in),
            .o_data (w_out)
        );
    end

    assign w_final = g_lvl[NL-1].w_out;
    assign sad_vld = r_vld[SAD_LATENCY-1];

`ifdef SAD_CAL_ZERO_IDLE_EN
    assign sad = w_final & {(DWIDTH+8){sad_vld}};
`else
    assign sad = w_final;
`endif

endmodule

// File: tb/tb_sad_cal_16x16.sv
// Self-checking bench for sad_cal_16x16: directed cases plus random traffic
// compared every cycle against a cycle-indexed behavioural model.
module tb_sad_cal_16x16;

    localparam int DW   = 8;
    localparam int BW   = 256 * DW;
    localparam int MAXC = 40000;
`ifdef SAD_CAL_ZERO_IDLE_EN
    localparam bit ZI = 1'b1;
`else
    localparam bit ZI = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cal_en = 1'b0;
    logic [BW-1:0] dina = '0;
    logic [BW-1:0] refi = '0;
    logic [DW+7:0] sad;
    logic          sad_vld;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bit req_v  [MAXC];
    int req_s  [MAXC];
    bit rst_at [MAXC];
    int last_sum = 0;

    always #5 clk = ~clk;

    sad_cal_16x16 #(.DWIDTH(DW), .PIPE_STAGE(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .dina    (dina),
        .refi    (refi),
        .cal_en  (cal_en),
        .sad     (sad),
        .sad_vld (sad_vld)
    );

    function automatic int ref_sad(input logic [BW-1:0] a,
                                   input logic [BW-1:0] b);
        int s;
        int pa;
        int pb;
        s = 0;
        for (int p = 0; p < 256; p++) begin
            pa = int'(a[p*DW +: DW]);
            pb = int'(b[p*DW +: DW]);
            s += (pa > pb) ? (pa - pb) : (pb - pa);
        end
        return s;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Record what each edge captured: a request, its SAD, or a reset.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC) begin
            rst_at[cyc] = rst;
            req_v[cyc]  = !rst && cal_en;
            req_s[cyc]  = (!rst && cal_en) ? ref_sad(dina, refi) : 0;
        end
    end

    // Output expected 7 edges after capture unless a reset intervened.
    always @(negedge clk) begin
        bit ev;
        int es;
        ev = 1'b0;
        if (rst) begin
            last_sum = 0;
        end else if (cyc >= 7 && cyc < MAXC) begin
            ev = req_v[cyc-7];
            for (int k = cyc - 6; k <= cyc; k++)
                if (rst_at[k]) ev = 1'b0;
        end
        if (ev) last_sum = req_s[cyc-7];
        es = (ZI && !ev) ? 0 : last_sum;
        check("model_vld", 32'(sad_vld), 32'(ev));
        check("model_sad", 32'(sad), es);
    end

    task automatic drive(input bit en, input logic [BW-1:0] a,
                         input logic [BW-1:0] b);
        @(negedge clk);
        #1;
        cal_en = en;
        dina   = a;
        refi   = b;
    endtask

    // One request; returns just after the capture edge with cal_en low.
    task automatic issue_one(input logic [BW-1:0] a, input logic [BW-1:0] b);
        drive(1'b1, a, b);
        @(negedge clk);
        #1;
        cal_en = 1'b0;
    endtask

    // Edges counted with the capture edge as edge 1; -1 on timeout.
    task automatic wait_vld(input int budget, output int edges,
                            output logic [15:0] v);
        edges = -1;
        v     = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (sad_vld) begin
                edges = k + 1;
                v     = sad;
                break;
            end
        end
    endtask

    function automatic logic [BW-1:0] rnd_blk();
        logic [BW-1:0] r;
        for (int w = 0; w < BW / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    logic [BW-1:0] ones;
    logic [BW-1:0] zeros;
    logic [BW-1:0] ta;
    logic [BW-1:0] tb;
    logic [15:0]   e4 [4];
    logic [15:0]   got [$];
    logic [15:0]   v;
    int            edges;
    int            first_k;
    int            last_k;
    int            stale;
    int            duty;

    initial begin
        ones  = '1;
        zeros = '0;
        e4    = '{16'hFF00, 16'h0000, 16'hFF00, 16'h0000};

        repeat (3) @(negedge clk);
        #1;
        check("reset_vld", 32'(sad_vld), 32'd0);
        check("reset_sad", 32'(sad), 32'd0);
        rst = 1'b0;

        issue_one(zeros, zeros);
        wait_vld(20, edges, v);
        check("zero_latency_edges", edges, 8);
        check("zero_sad", 32'(v), 32'h0000);

        drive(1'b1, zeros, ones);
        drive(1'b1, ones, ones);
        drive(1'b1, ones, zeros);
        drive(1'b1, zeros, zeros);
        drive(1'b0, zeros, zeros);
        got.delete();
        first_k = -1;
        last_k  = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (sad_vld) begin
                got.push_back(sad);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        check("b2b_count", got.size(), 4);
        check("b2b_contig", last_k - first_k, 3);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check("b2b_value", 32'(got[i]), 32'(e4[i]));

        ta = '0;
        ta[(15*16+15)*DW +: DW] = 8'h80;
        issue_one(ta, zeros);
        wait_vld(20, edges, v);
        check("lastpix_edges", edges, 8);
        check("lastpix_sad", 32'(v), 32'h0080);

        issue_one(ones, zeros);
        wait_vld(20, edges, v);
        check("full_sad", 32'(v), 32'hFF00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_vld", 32'(sad_vld), 32'd0);
            check("idle_sad", 32'(sad), ZI ? 32'h0 : 32'hFF00);
        end

        for (int i = 0; i < 5; i++) drive(1'b1, rnd_blk(), rnd_blk());
        @(negedge clk);
        #1;
        cal_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("midrst_vld", 32'(sad_vld), 32'd0);
        check("midrst_sad", 32'(sad), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sad_vld) stale++;
        end
        check("midrst_stale", stale, 0);
        ta = rnd_blk();
        tb = rnd_blk();
        issue_one(ta, tb);
        wait_vld(20, edges, v);
        check("postrst_edges", edges, 8);
        check("postrst_sad", 32'(v), ref_sad(ta, tb));

        for (int ph = 0; ph < 2; ph++) begin
            duty = (ph == 0) ? 6 : 94;
            for (int i = 0; i < 16000; i++) begin
                ta = rnd_blk();
                case ($urandom_range(3))
                    0: tb = ~ta;
                    1: tb = ta ^ {BW/32{$urandom() & 32'h0303_0303}};
                    default: tb = rnd_blk();
                endcase
                drive($urandom_range(99) < duty, ta, tb);
            end
        end
        drive(1'b0, zeros, zeros);
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
